// File: rtl/seq_pattern_tx_if.sv
// Serial pattern transmitter bus: request inputs and serial/status outputs.
// Master drives the request side, slave is the transmitter.
interface seq_pattern_tx_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
);
  logic             start;
  logic             abort;
  logic [PAT_W-1:0] pat_in;
  logic [CNT_W-1:0] reps;
  logic             dout;
  logic             dvalid;
  logic             busy;
  logic             done;
  logic [1:0]       pst;

  modport master (
    output start, abort, pat_in, reps,
    input  dout, dvalid, busy, done, pst
  );

  modport slave (
    input  start, abort, pat_in, reps,
    output dout, dvalid, busy, done, pst
  );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a latched pattern out MSB-first, N times.
// Define SEQ_TX_GAP_EN to insert one idle GAP cycle between repetitions.
module seq_pattern_tx #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst,
  seq_pattern_tx_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    GAP   = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam int BW = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  localparam logic [BW-1:0] LAST = BW'(PAT_W - 1);

  state_t           r_state;
  logic [PAT_W-1:0] r_pat;
  logic [PAT_W-1:0] r_sr;
  logic [BW-1:0]    r_bit;
  logic [CNT_W-1:0] r_rep;
  logic             r_dout;
  logic             r_dvalid;
  logic             r_busy;
  logic             r_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_pat    <= '0;
      r_sr     <= '0;
      r_bit    <= '0;
      r_rep    <= '0;
      r_dout   <= 1'b0;
      r_dvalid <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start && bus.reps != '0) begin
            r_state  <= SHIFT;
            r_pat    <= bus.pat_in;
            r_sr     <= {bus.pat_in[PAT_W-2:0], 1'b0};
            r_bit    <= LAST;
            r_rep    <= bus.reps;
            r_dout   <= bus.pat_in[PAT_W-1];
            r_dvalid <= 1'b1;
            r_busy   <= 1'b1;
          end else begin
            r_dout   <= 1'b0;
            r_dvalid <= 1'b0;
            r_busy   <= 1'b0;
          end
        end
        SHIFT: begin
          if (bus.abort) begin
            r_state  <= IDLE;
            r_dout   <= 1'b0;
            r_dvalid <= 1'b0;
            r_busy   <= 1'b0;
          end else if (r_bit == '0) begin
            if (r_rep > CNT_W'(1)) begin
              r_rep <= r_rep - 1'b1;
`ifdef SEQ_TX_GAP_EN
              r_state  <= GAP;
              r_dout   <= 1'b0;
              r_dvalid <= 1'b0;
`else
              r_sr     <= {r_pat[PAT_W-2:0], 1'b0};
              r_bit    <= LAST;
              r_dout   <= r_pat[PAT_W-1];
              r_dvalid <= 1'b1;
`endif
            end else begin
              r_state  <= DONE;
              r_rep    <= '0;
              r_dout   <= 1'b0;
              r_dvalid <= 1'b0;
              r_done   <= 1'b1;
            end
          end else begin
            r_sr     <= {r_sr[PAT_W-2:0], 1'b0};
            r_bit    <= r_bit - 1'b1;
            r_dout   <= r_sr[PAT_W-1];
          end
        end
`ifdef SEQ_TX_GAP_EN
        GAP: begin
          if (bus.abort) begin
            r_state  <= IDLE;
            r_busy   <= 1'b0;
          end else begin
            r_state  <= SHIFT;
            r_sr     <= {r_pat[PAT_W-2:0], 1'b0};
            r_bit    <= LAST;
            r_dout   <= r_pat[PAT_W-1];
            r_dvalid <= 1'b1;
          end
        end
`endif
        DONE: begin
          r_state  <= IDLE;
          r_dout   <= 1'b0;
          r_dvalid <= 1'b0;
          r_busy   <= 1'b0;
        end
        // GAP lands here when the gap feature is compiled out
        default: begin
          r_state  <= IDLE;
          r_dout   <= 1'b0;
          r_dvalid <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dout   = r_dout;
  assign bus.dvalid = r_dvalid;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.pst    = r_state;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Randomized bench for seq_pattern_tx against a per-cycle stream model.
// Build with +define+SEQ_TX_GAP_EN to exercise the gap variant.
module tb_seq_pattern_tx;

  localparam int PAT_W = 4;
  localparam int CNT_W = 8;

  typedef struct packed {
    logic       v;
    logic       b;
    logic [1:0] st;
  } exp_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  seq_pattern_tx_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();

  seq_pattern_tx #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [5:0] got;
    rst = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.pat_in = '0;
    bus.reps = '0;
    #2;
    got = {bus.dout, bus.dvalid, bus.busy, bus.done, bus.pst};
    n_vec++;
    if (got !== 6'b0) begin
      n_err++;
      $display("FAIL reset got %b exp %b", got, 6'b0);
    end
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  // Expected per-cycle stream built from the pattern/rep rules,
  // followed by one trailing idle cycle.
  task automatic run_tx(input logic [PAT_W-1:0] pat,
                        input logic [CNT_W-1:0] rp,
                        input int abort_at,
                        input bit noise,
                        input string nm);
    exp_t       q[$];
    exp_t       e;
    logic [5:0] got;
    logic [5:0] exp;
    for (int r = 0; r < int'(rp); r++) begin
`ifdef SEQ_TX_GAP_EN
      if (r > 0) q.push_back('{v: 1'b0, b: 1'b0, st: 2'b10});
`endif
      for (int k = PAT_W - 1; k >= 0; k--)
        q.push_back('{v: 1'b1, b: pat[k], st: 2'b01});
    end
    if (rp != '0) q.push_back('{v: 1'b0, b: 1'b0, st: 2'b11});
    if (abort_at >= 0) begin
      while (q.size() > abort_at + 1) void'(q.pop_back());
    end
    q.push_back('{v: 1'b0, b: 1'b0, st: 2'b00});
    bus.start = 1'b1;
    bus.pat_in = pat;
    bus.reps = rp;
    bus.abort = 1'b0;
    step();
    for (int i = 0; i < q.size(); i++) begin
      e = q[i];
      exp = {e.v & e.b, e.v, e.st != 2'b00, e.st == 2'b11, e.st};
      got = {bus.dout, bus.dvalid, bus.busy, bus.done, bus.pst};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL %s cyc %0d got %b exp %b", nm, i, got, exp);
      end
      bus.start = 1'b0;
      bus.abort = 1'b0;
      if (noise && e.st != 2'b00) begin
        bus.start = 1'($urandom);
        bus.pat_in = PAT_W'($urandom);
        bus.reps = CNT_W'($urandom);
        if (e.st == 2'b11) bus.abort = 1'($urandom);
      end
      if (i == abort_at) bus.abort = 1'b1;
      step();
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  task automatic test_zero_reps();
    logic [5:0] got;
    bus.start = 1'b1;
    bus.pat_in = 4'b1010;
    bus.reps = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      got = {bus.dout, bus.dvalid, bus.busy, bus.done, bus.pst};
      n_vec++;
      if (got !== 6'b0) begin
        n_err++;
        $display("FAIL zero_reps cyc %0d got %b exp %b", i, got, 6'b0);
      end
    end
    bus.start = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    logic [5:0] got;
    bus.start = 1'b1;
    bus.pat_in = 4'b1010;
    bus.reps = 8'd3;
    step();
    bus.start = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
    got = {bus.dout, bus.dvalid, bus.busy, bus.done, bus.pst};
    n_vec++;
    if (got !== 6'b0) begin
      n_err++;
      $display("FAIL async_reset got %b exp %b", got, 6'b0);
    end
    step();
    rst = 1'b1;
    step();
    got = {bus.dout, bus.dvalid, bus.busy, bus.done, bus.pst};
    n_vec++;
    if (got !== 6'b0) begin
      n_err++;
      $display("FAIL post_reset got %b exp %b", got, 6'b0);
    end
  endtask

  task automatic test_random();
    logic [PAT_W-1:0] pat;
    logic [CNT_W-1:0] rp;
    int               n;
    int               ab;
    for (int t = 0; t < 25; t++) begin
      pat = PAT_W'($urandom);
      rp = CNT_W'($urandom_range(1, 5));
      n = PAT_W * int'(rp);
`ifdef SEQ_TX_GAP_EN
      n = n + int'(rp) - 1;
`endif
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      run_tx(pat, rp, ab, 1'($urandom), "random");
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    run_tx(4'b1010, 8'd1, -1, 1'b0, "single");
    run_tx(4'b1010, 8'd3, -1, 1'b0, "three_reps");
    test_zero_reps();
    run_tx(4'b1010, 8'd2, -1, 1'b1, "busy_noise");
    run_tx(4'b1010, 8'd2, PAT_W + 2, 1'b0, "abort");
    run_tx(4'b0110, 8'd2, 0, 1'b0, "abort_first");
    run_tx(4'b1001, 8'd2, -1, 1'b0, "gap_pair");
    test_async_reset();
    run_tx(4'b1111, 8'd1, -1, 1'b0, "after_rst");
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
